pwm_output_stage: RTL and testbench
===================================

// Module: pwm_output_stage
// PURPOSE
//   Consumes the five configuration bytes written over SPI (output enables, PWM
//   enables, duty cycle) and drives the 16 chip outputs {uio_out, uo_out}.
//   Contains a clock prescaler, an 8-bit PWM period counter and a duty-cycle
//   shadow register updated only at period boundaries (glitch-free duty changes).
//   Sits directly downstream of the SPI register file; outputs go straight to pads.
// PARAMETERS
//   CLK_DIV  13  clk cycles per PWM counter step (10 MHz / 13 / 256 = ~3.0 kHz); legal >= 1
//   PRE_W    8   prescaler counter width; must satisfy 2**PRE_W >= CLK_DIV
// PORTS
//   clk              in   1   system clock
//   rst              in   1   asynchronous reset, active high
//   en_reg_out_7_0   in   8   per-bit output enable, out[7:0]
//   en_reg_out_15_8  in   8   per-bit output enable, out[15:8]
//   en_reg_pwm_7_0   in   8   per-bit PWM mode select, out[7:0]
//   en_reg_pwm_15_8  in   8   per-bit PWM mode select, out[15:8]
//   pwm_duty_cycle   in   8   requested duty (0x00 = 0 %, 0xFF = 100 %)
//   out              out  16  registered pad drive; [7:0] -> uo_out, [15:8] -> uio_out
//   period_start     out  1   one-cycle pulse on the first clk of each PWM period
// BEHAVIOUR
//   Reset (rst=1, async): pre_cnt=0, pwm_cnt=0, duty_q=0x00, out=16'h0000,
//     period_start=0. Holds while rst=1; first count after rst deasserts.
//   Prescaler: pre_cnt counts 0..CLK_DIV-1 then wraps to 0; tick=1 when
//     pre_cnt==CLK_DIV-1. CLK_DIV=1 -> tick every cycle.
//   Period counter: pwm_cnt (8 b) increments on tick, wraps 255->0 (256 steps,
//     period = 256*CLK_DIV clk). No other way to load/clear except reset.
//   Shadow: on tick with pwm_cnt==255, duty_q <= pwm_duty_cycle (same edge as the
//     wrap to 0). pwm_duty_cycle changes mid-period have no effect until then.
//     First period after reset uses duty_q=0x00.
//   period_start: registered; 1 for exactly one clk, the clk in which pwm_cnt
//     first reads 0 after a wrap. Not asserted for the post-reset period.
//   PWM level: pwm_lvl = (duty_q==8'hFF) ? 1 : (pwm_cnt < duty_q).
//     duty 0x00 -> always 0; 0xFF -> always 1 (special-cased, not 255/256);
//     else high for duty_q counter steps = duty_q*CLK_DIV clk per period.
//   Per bit i (0..15), en_out = {en_reg_out_15_8, en_reg_out_7_0}, same for en_pwm:
//     en_out[i]=0                -> out[i]=0 (regardless of en_pwm[i])
//     en_out[i]=1, en_pwm[i]=0   -> out[i]=1 (static high)
//     en_out[i]=1, en_pwm[i]=1   -> out[i]=pwm_lvl
//   Latency: out is registered; an enable change or pwm_cnt/duty_q change is
//     visible on out 1 clk later. Enables are not shadowed (take effect immediately).
//   All PWM bits share one counter/duty: edges are simultaneous across bits.
//   Reset mid-period: outputs drop to 0 asynchronously; counting restarts at 0
//     with duty_q=0, pending duty value discarded.
// TESTING
//   1 Assert rst mid-run with all enables 0xFF -> out=0x0000 same cycle, period_start=0.
//   2 en_reg_out_7_0=0x01, pwm enables 0 -> out=0x0001 exactly 1 clk after write.
//   3 CLK_DIV=13, duty=0x80, all enables 0xFF, after first period_start -> every out bit
//     high 1664 clk, low 1664 clk, period 3328 clk, period_start spacing 3328.
//   4 duty=0x00 -> out=0x0000 for 2 full periods; duty=0xFF -> out=0xFFFF for 2 periods,
//     no single-cycle low at wrap.
//   5 duty 0x40 then 0xC0 written at pwm_cnt=0x10 -> current period high 0x40*13 clk;
//     next period (after period_start) high 0xC0*13 clk.
//   6 en_reg_pwm_15_8=0xFF, en_reg_out_15_8=0x00 -> out[15:8]=0; then en_reg_out_15_8=0x0F
//     -> out[11:8] follow PWM, out[15:12] stay 0.

Source files
------------

// File: rtl/pwm_output_stage.sv
// PWM output stage: prescaler, 8-bit period counter, period-boundary duty shadow
// and per-pad enable/PWM muxing into registered 16-bit pad drive.

module pwm_lane (
    input  logic clk,
    input  logic rst,
    input  logic en_out,
    input  logic en_pwm,
    input  logic pwm_lvl,
    output logic out_q
);
    logic out_d;

    always_comb begin
        out_d = en_out & (~en_pwm | pwm_lvl);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= 1'b0;
        else     out_q <= out_d;
    end
endmodule

module pwm_output_stage #(
    parameter int CLK_DIV = 13,
    parameter int PRE_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);
    localparam int NUM_LANES = 16;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic [7:0]       duty_q, duty_d;
    logic             period_start_q, period_start_d;
    logic             tick, wrap, pwm_lvl;
    logic [NUM_LANES-1:0] en_out, en_pwm;

    always_comb begin
        tick      = (pre_cnt_q == PRE_MAX);
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        // Duty is sampled only on the 255->0 step so each period is glitch-free
        wrap           = tick && (pwm_cnt_q == 8'hFF);
        duty_d         = wrap ? pwm_duty_cycle : duty_q;
        period_start_d = wrap;
        // 0xFF is full-on rather than 255/256
        pwm_lvl = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
        en_out  = {en_reg_out_15_8, en_reg_out_7_0};
        en_pwm  = {en_reg_pwm_15_8, en_reg_pwm_7_0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= 8'h00;
            duty_q         <= 8'h00;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            duty_q         <= duty_d;
            period_start_q <= period_start_d;
        end
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        pwm_lane u_lane (
            .clk     (clk),
            .rst     (rst),
            .en_out  (en_out[i]),
            .en_pwm  (en_pwm[i]),
            .pwm_lvl (pwm_lvl),
            .out_q   (out[i])
        );
    end

    assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_output_stage.sv
// Directed bench for pwm_output_stage with CLK_DIV=13 (period 3328 clk).
module tb_pwm_output_stage;
    localparam int PER = 256 * 13;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
    logic [15:0] out;
    logic        ps;
    int          n_checks = 0;
    int          n_fail = 0;

    pwm_output_stage #(.CLK_DIV(13), .PRE_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .en_reg_out_7_0  (eo_lo),
        .en_reg_out_15_8 (eo_hi),
        .en_reg_pwm_7_0  (ep_lo),
        .en_reg_pwm_15_8 (ep_hi),
        .pwm_duty_cycle  (duty),
        .out             (out),
        .period_start    (ps)
    );

    always #5 clk = ~clk;

    // Waits (bounded) for a negedge on which period_start is high.
    task automatic wait_ps(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < PER + 100; c++) begin
            @(negedge clk);
            if (ps) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL reset_out: got %h want 0000", out); end
        n_checks++; if (ps !== 1'b0) begin n_fail++; $display("FAIL reset_ps: got %b want 0", ps); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_static;
        @(negedge clk); eo_lo = 8'h01;
        n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL static_pre: got %h want 0000", out); end
        @(negedge clk);
        n_checks++; if (out !== 16'h0001) begin n_fail++; $display("FAIL static_1clk: got %h want 0001", out); end
        eo_lo = 8'h00;
        @(negedge clk);
        n_checks++; if (out !== 16'h0000) begin n_fail++; $display("FAIL static_off: got %h want 0000", out); end
    endtask

    task automatic test_pwm_half;
        bit ok;
        int hi, first_low, extra, bad;
        bit ps_end;
        eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'h80;
        wait_ps(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL half_wait_ps: got timeout want pulse"); end
        hi = 0; first_low = 0; extra = 0; bad = 0; ps_end = 1'b0;
        for (int c = 1; c <= PER; c++) begin
            @(negedge clk);
            if (out === 16'hFFFF) hi++;
            else if (out !== 16'h0000) bad++;
            if (out === 16'h0000 && first_low == 0) first_low = c;
            if (c < PER && ps) extra++;
            if (c == PER) ps_end = ps;
        end
        n_checks++; if (hi != 1664) begin n_fail++; $display("FAIL half_high: got %0d want 1664", hi); end
        n_checks++; if (first_low != 1665) begin n_fail++; $display("FAIL half_fall: got %0d want 1665", first_low); end
        n_checks++; if (ps_end !== 1'b1 || extra != 0) begin n_fail++; $display("FAIL half_ps_spacing: got end=%b extra=%0d want 1/0", ps_end, extra); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL half_simultaneous: got %0d split cycles want 0", bad); end
    endtask

    task automatic test_reset_mid;
        int nz, c;
        repeat (100) @(negedge clk);
        n_checks++; if (out !== 16'hFFFF) begin n_fail++; $display("FAIL mid_pre: got %h want ffff", out); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out !== 16'h0000 || ps !== 1'b0) begin n_fail++; $display("FAIL mid_async: got %h/%b want 0000/0", out, ps); end
        @(negedge clk); rst = 1'b0;
        nz = 0;
        for (c = 1; c <= PER + 100; c++) begin
            @(negedge clk);
            if (out !== 16'h0000) nz++;
            if (ps) break;
        end
        n_checks++; if (c != PER) begin n_fail++; $display("FAIL mid_first_ps: got %0d want %0d", c, PER); end
        n_checks++; if (nz != 0) begin n_fail++; $display("FAIL mid_duty_cleared: got %0d high cycles want 0", nz); end
    endtask

    task automatic test_duty_extremes;
        bit ok;
        int bad;
        duty = 8'h00;
        wait_ps(ok);
        bad = 0;
        for (int c = 1; c <= 2 * PER; c++) begin
            @(negedge clk);
            if (out !== 16'h0000) bad++;
        end
        n_checks++; if (!ok || bad != 0) begin n_fail++; $display("FAIL duty00: got ok=%b bad=%0d want 1/0", ok, bad); end
        duty = 8'hFF;
        wait_ps(ok);
        bad = 0;
        for (int c = 1; c <= 2 * PER; c++) begin
            @(negedge clk);
            if (out !== 16'hFFFF) bad++;
        end
        n_checks++; if (!ok || bad != 0) begin n_fail++; $display("FAIL dutyff: got ok=%b bad=%0d want 1/0", ok, bad); end
    endtask

    task automatic test_shadow;
        bit ok;
        int hi;
        bit ps_end;
        duty = 8'h40;
        wait_ps(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL shadow_wait_ps: got timeout want pulse"); end
        hi = 0; ps_end = 1'b0;
        for (int c = 1; c <= PER; c++) begin
            @(negedge clk);
            if (c == 16 * 13) duty = 8'hC0;
            if (out === 16'hFFFF) hi++;
            if (c == PER) ps_end = ps;
        end
        n_checks++; if (hi != 8'h40 * 13) begin n_fail++; $display("FAIL shadow_cur: got %0d want %0d", hi, 8'h40 * 13); end
        n_checks++; if (ps_end !== 1'b1) begin n_fail++; $display("FAIL shadow_ps: got %b want 1", ps_end); end
        hi = 0;
        for (int c = 1; c <= PER; c++) begin
            @(negedge clk);
            if (out === 16'hFFFF) hi++;
        end
        n_checks++; if (hi != 8'hC0 * 13) begin n_fail++; $display("FAIL shadow_next: got %0d want %0d", hi, 8'hC0 * 13); end
    endtask

    task automatic test_en_gating;
        bit ok;
        int hi, bad;
        eo_hi = 8'h00; ep_hi = 8'hFF;
        @(negedge clk);
        n_checks++; if (out[15:8] !== 8'h00) begin n_fail++; $display("FAIL gate_off: got %h want 00", out[15:8]); end
        eo_hi = 8'h0F;
        @(negedge clk);
        n_checks++; if (out !== 16'h0FFF) begin n_fail++; $display("FAIL gate_partial: got %h want 0fff", out); end
        wait_ps(ok);
        hi = 0; bad = 0;
        for (int c = 1; c <= PER; c++) begin
            @(negedge clk);
            if (out[11:8] === 4'hF) hi++;
            else if (out[11:8] !== 4'h0) bad++;
            if (out[15:12] !== 4'h0) bad++;
        end
        n_checks++; if (!ok || hi != 8'hC0 * 13 || bad != 0) begin n_fail++; $display("FAIL gate_pwm: got ok=%b hi=%0d bad=%0d want 1/%0d/0", ok, hi, bad, 8'hC0 * 13); end
    endtask

    initial begin
        rst = 1'b1; eo_lo = 8'h00; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00; duty = 8'h00;
        repeat (3) @(negedge clk);
        test_reset;
        test_static;
        test_pwm_half;
        test_reset_mid;
        test_duty_extremes;
        test_shadow;
        test_en_gating;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
